// File: rtl/cfar_frame_ctrl.sv
// cfar_frame_ctrl: frame sequencer in front of the CFAR detector core.
// Numbers accepted samples, flags end-of-packet, holds the scan direction for
// the frame, inserts a drain gap and publishes a per-frame detection summary.
// Optional build macro CFAR_PEAK_CAP_EN: cap forwarded detections at MAX_PEAKS
// per frame and report a sticky overflow on frame_overflow.
module cfar_frame_ctrl #(
   parameter int unsigned INPUT_WIDTH  = 32,
   parameter int unsigned IDX_W        = 10,
   parameter int unsigned DRAIN_CYCLES = 15,
   parameter int unsigned PEAK_W       = 10,
   parameter int unsigned MAX_PEAKS    = 64
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic [IDX_W:0]         cfg_frame_len,
   input  logic                   cfg_reverse,
   input  logic [INPUT_WIDTH-1:0] s_power,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic [INPUT_WIDTH-1:0] power_in,
   output logic [IDX_W-1:0]       index_in,
   output logic                   input_valid,
   output logic                   eop_in,
   output logic                   reverse,
   input  logic                   max_valid,
   input  logic [IDX_W-1:0]       index_out,
   output logic                   peak_valid,
   output logic [IDX_W-1:0]       peak_index,
   output logic                   frame_done,
   output logic [PEAK_W-1:0]      frame_peaks,
   output logic                   frame_overflow,
   output logic                   busy
);

`ifdef CFAR_PEAK_CAP_EN
   localparam bit CAP_EN = 1'b1;
`else
   localparam bit CAP_EN = 1'b0;
`endif

   localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [IDX_W:0]     len_q;
   logic [IDX_W:0]     count_q;
   logic [DRAIN_W-1:0] drain_q;
   logic [PEAK_W-1:0]  peak_cnt_q, peak_cnt_d;
   logic               ovf_q, ovf_d;
   logic               max_valid_q;
   logic               start, accept, last, close, rise, count_en, hit;

   // s_ready and busy decode straight from the state register, never from s_valid
   assign s_ready  = (state_q == ST_STREAM);
   assign busy     = (state_q != ST_IDLE);
   assign start    = (state_q == ST_IDLE) && enable && (cfg_frame_len >= (IDX_W+1)'(2));
   assign accept   = s_ready && s_valid;
   assign last     = (count_q == (len_q - (IDX_W+1)'(1)));
   assign close    = (state_q == ST_DRAIN) && (drain_q == DRAIN_W'(1));
   assign rise     = max_valid && !max_valid_q;
   assign count_en = rise && ((state_q == ST_STREAM) || (state_q == ST_DRAIN));

   // Next-state decode of the frame sequencer
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_STREAM;
         ST_STREAM: if (accept && last) state_d = ST_DRAIN;
         ST_DRAIN:  if (close) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Detection accounting: saturating count, optional cap with sticky overflow
   always_comb begin
      peak_cnt_d = peak_cnt_q;
      ovf_d      = ovf_q;
      hit        = 1'b0;
      if (count_en) begin
         if (CAP_EN && (32'(peak_cnt_q) >= MAX_PEAKS)) begin
            ovf_d = 1'b1;
         end else begin
            hit = 1'b1;
            if (peak_cnt_q != '1) peak_cnt_d = peak_cnt_q + PEAK_W'(1);
         end
      end
   end

   // State register and latched frame configuration
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         reverse <= 1'b0;
         count_q <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            len_q   <= cfg_frame_len;
            reverse <= cfg_reverse;
            count_q <= '0;
         end
         if (accept) count_q <= count_q + (IDX_W+1)'(1);
         if (accept && last) begin
            drain_q <= DRAIN_W'(DRAIN_CYCLES);
         end else if (state_q == ST_DRAIN) begin
            drain_q <= drain_q - DRAIN_W'(1);
         end
      end
   end

   // Sample path to the core; index_in holds across upstream gaps
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         power_in    <= '0;
         index_in    <= '0;
         input_valid <= 1'b0;
         eop_in      <= 1'b0;
      end else begin
         input_valid <= accept;
         eop_in      <= accept && last;
         if (accept) begin
            power_in <= s_power;
            index_in <= count_q[IDX_W-1:0];
         end
      end
   end

   // Edge detector, per-frame peak counter and forwarded detections
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         max_valid_q <= 1'b0;
         peak_cnt_q  <= '0;
         ovf_q       <= 1'b0;
         peak_valid  <= 1'b0;
         peak_index  <= '0;
      end else begin
         max_valid_q <= max_valid;
         peak_valid  <= hit;
         if (hit) peak_index <= index_out;
         if (start) begin
            peak_cnt_q <= '0;
            ovf_q      <= 1'b0;
         end else begin
            peak_cnt_q <= peak_cnt_d;
            ovf_q      <= ovf_d;
         end
      end
   end

   // Frame summary; uses next-state counts so a detection on the closing cycle is included
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_done     <= 1'b0;
         frame_peaks    <= '0;
         frame_overflow <= 1'b0;
      end else begin
         frame_done <= close;
         if (close) begin
            frame_peaks    <= peak_cnt_d;
            frame_overflow <= ovf_d;
         end
      end
   end

endmodule

// File: tb/tb_cfar_frame_ctrl.sv
// Directed bench for cfar_frame_ctrl (defaults, MAX_PEAKS=4).
// Expectations adapt to the CFAR_PEAK_CAP_EN build macro.
module tb_cfar_frame_ctrl;

   localparam int IDX_W = 10;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [10:0] cfg_frame_len;
   logic        cfg_reverse;
   logic [31:0] s_power;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] power_in;
   logic [9:0]  index_in;
   logic        input_valid;
   logic        eop_in;
   logic        reverse;
   logic        max_valid;
   logic [9:0]  index_out;
   logic        peak_valid;
   logic [9:0]  peak_index;
   logic        frame_done;
   logic [9:0]  frame_peaks;
   logic        frame_overflow;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   cfar_frame_ctrl #(.MAX_PEAKS(4)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_frame_len(cfg_frame_len),
      .cfg_reverse(cfg_reverse), .s_power(s_power), .s_valid(s_valid), .s_ready(s_ready),
      .power_in(power_in), .index_in(index_in), .input_valid(input_valid), .eop_in(eop_in),
      .reverse(reverse), .max_valid(max_valid), .index_out(index_out),
      .peak_valid(peak_valid), .peak_index(peak_index), .frame_done(frame_done),
      .frame_peaks(frame_peaks), .frame_overflow(frame_overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int i);
      return 32'hC0DE_0000 ^ (32'(i) * 32'h0000_9E37);
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Frame monitor, sampled on the falling edge
   int             iv_cnt, eop_cnt, eop_idx, idx_err, hold_err, pow_err, rev_err, fd_cnt;
   int             exp_idx;
   logic           exp_rev;
   logic [9:0]     last_idx;
   int             pk_idx[$];

   task automatic clear_mon(input logic rev);
      iv_cnt = 0; eop_cnt = 0; eop_idx = -1; idx_err = 0; hold_err = 0;
      pow_err = 0; rev_err = 0; fd_cnt = 0; exp_idx = 0; exp_rev = rev;
      last_idx = index_in;
      pk_idx.delete();
   endtask

   always begin
      @(negedge clk);
      if (input_valid) begin
         iv_cnt++;
         if (index_in != exp_idx[IDX_W-1:0]) idx_err++;
         if (power_in != pat(exp_idx)) pow_err++;
         exp_idx++;
         if (eop_in) begin
            eop_cnt++;
            eop_idx = int'(index_in);
         end
      end else begin
         if (eop_in) eop_cnt++;
         if (index_in != last_idx) hold_err++;
      end
      last_idx = index_in;
      if (busy && (reverse != exp_rev)) rev_err++;
      if (peak_valid) pk_idx.push_back(int'(peak_index));
      if (frame_done) fd_cnt++;
   end

   // Runs one frame; det selects the detection pattern, abort_at asserts reset after
   // that many accepted samples. fd_cyc = edges from enable to frame_done visible.
   task automatic run_frame(input int len, input logic rev, input bit gap, input int det,
                            input int abort_at, output int fd_cyc);
      int cyc;
      int sent;
      bit acc;
      cfg_frame_len = 11'(len);
      cfg_reverse   = rev;
      enable        = 1'b1;
      clear_mon(rev);
      cyc    = 0;
      sent   = 0;
      fd_cyc = -1;
      while (cyc < 4000) begin
         s_valid = gap ? (cyc % 2 == 1) : 1'b1;
         s_power = pat(sent);
         case (det)
            1: begin
               max_valid = (cyc >= 101 && cyc <= 103) || (cyc == 501);
               index_out = (cyc < 300) ? 10'd100 : 10'd500;
            end
            2: begin
               max_valid = cyc inside {4, 6, 8, 10, 12, 30};
               index_out = 10'(10 + cyc);
            end
            default: max_valid = 1'b0;
         endcase
         acc = s_valid && s_ready;
         tick();
         cyc++;
         if (acc) sent++;
         if (cyc == 1) begin
            enable        = 1'b0;
            cfg_reverse   = ~rev;
            cfg_frame_len = 11'd3;
         end
         if (abort_at >= 0 && sent == abort_at) begin
            reset_n = 1'b0;
            break;
         end
         if (frame_done) begin
            fd_cyc = cyc;
            break;
         end
      end
      s_valid   = 1'b0;
      max_valid = 1'b0;
   endtask

   int fd;

   initial begin
      reset_n = 1'b0; enable = 1'b0; cfg_frame_len = '0; cfg_reverse = 1'b0;
      s_power = '0; s_valid = 1'b0; max_valid = 1'b0; index_out = '0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      clear_mon(1'b0);
      check("rst s_ready", s_ready, 0);
      check("rst busy", busy, 0);
      check("rst input_valid", input_valid, 0);
      check("rst eop_in", eop_in, 0);
      check("rst power_in", power_in, 0);
      check("rst index_in", index_in, 0);
      check("rst reverse", reverse, 0);
      check("rst peak_valid", peak_valid, 0);
      check("rst frame_done", frame_done, 0);
      check("rst frame_peaks", frame_peaks, 0);
      check("rst frame_overflow", frame_overflow, 0);

      // Too-short frame request plus a detection edge while idle
      cfg_frame_len = 11'd1; enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         max_valid = (i == 2 || i == 3);
         index_out = 10'd77;
         tick();
         check("len1 busy", busy, 0);
      end
      check("len1 s_ready", s_ready, 0);
      enable = 1'b0; max_valid = 1'b0;
      repeat (2) tick();
      check("idle edge peaks", pk_idx.size(), 0);

      // Full-length frame, reverse=1, detections at 100 (held 3 cycles) and 500
      run_frame(1024, 1'b1, 1'b0, 1, -1, fd);
      repeat (3) tick();
      check("len1024 done cycle", fd, 1040);
      check("len1024 samples", iv_cnt, 1024);
      check("len1024 eop count", eop_cnt, 1);
      check("len1024 eop index", eop_idx, 1023);
      check("len1024 index seq", idx_err, 0);
      check("len1024 power", pow_err, 0);
      check("len1024 reverse held", rev_err, 0);
      check("len1024 done pulses", fd_cnt, 1);
      check("len1024 peak pulses", pk_idx.size(), 2);
      if (pk_idx.size() == 2) begin
         check("len1024 peak0 index", pk_idx[0], 100);
         check("len1024 peak1 index", pk_idx[1], 500);
      end
      check("len1024 frame_peaks", frame_peaks, 2);
      check("len1024 overflow", frame_overflow, 0);
      check("len1024 idle after", busy, 0);

      // Stalled frame, len=8, six detections, last one on the closing drain cycle
      run_frame(8, 1'b0, 1'b1, 2, -1, fd);
      repeat (3) tick();
      check("gap done cycle", fd, 31);
      check("gap samples", iv_cnt, 8);
      check("gap eop count", eop_cnt, 1);
      check("gap eop index", eop_idx, 7);
      check("gap index seq", idx_err, 0);
      check("gap index hold", hold_err, 0);
      check("gap power", pow_err, 0);
      check("gap reverse held", rev_err, 0);
      check("gap done pulses", fd_cnt, 1);
`ifdef CFAR_PEAK_CAP_EN
      check("cap peak pulses", pk_idx.size(), 4);
      if (pk_idx.size() == 4) check("cap last peak index", pk_idx[3], 20);
      check("cap frame_peaks", frame_peaks, 4);
      check("cap overflow", frame_overflow, 1);
`else
      check("nocap peak pulses", pk_idx.size(), 6);
      if (pk_idx.size() == 6) begin
         check("nocap peak4 index", pk_idx[4], 22);
         check("nocap peak5 index", pk_idx[5], 40);
      end
      check("nocap frame_peaks", frame_peaks, 6);
      check("nocap overflow", frame_overflow, 0);
`endif

      // Reset in the middle of a frame after 37 samples
      run_frame(100, 1'b1, 1'b0, 0, 37, fd);
      #1;
      check("abort busy", busy, 0);
      check("abort s_ready", s_ready, 0);
      check("abort input_valid", input_valid, 0);
      check("abort index_in", index_in, 0);
      check("abort power_in", power_in, 0);
      check("abort reverse", reverse, 0);
      check("abort frame_peaks", frame_peaks, 0);
      tick();
      reset_n = 1'b1;
      enable  = 1'b0;
      s_valid = 1'b1;
      clear_mon(1'b0);
      repeat (40) tick();
      s_valid = 1'b0;
      check("post-abort done pulses", fd_cnt, 0);
      check("post-abort samples", iv_cnt, 0);
      check("post-abort busy", busy, 0);

      // Minimum-length frame after recovery
      run_frame(2, 1'b0, 1'b0, 0, -1, fd);
      repeat (3) tick();
      check("len2 done cycle", fd, 18);
      check("len2 samples", iv_cnt, 2);
      check("len2 eop index", eop_idx, 1);
      check("len2 done pulses", fd_cnt, 1);
      check("len2 frame_done low", frame_done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
